fetch_sequencer: RTL

Front-end control sequencer that drives the datapath's instruction-fetch controls.
- Reads a 16-bit instruction from byte-wide memory at the PC as two byte reads, low byte first, into the IR.
- Increments the PC on each byte read, decodes the opcode and hands execution to a downstream execute controller.
- Sits upstream of the ALU/register datapath, providing its Mem, IR and ARF(PC) control inputs.

---
 rtl/fetch_seq_pkg.sv | 14 +
 rtl/fetch_sequencer_exec_watchdog.sv | 17 +
 rtl/fetch_sequencer.sv | 80 ++++++++
 3 files changed

// File: rtl/fetch_seq_pkg.sv
// fetch_seq_pkg: shared states, ARF/memory encodings and helpers for the fetch sequencer
package fetch_seq_pkg;
  typedef enum logic [2:0] {IDLE, FETCH_L, FETCH_H, DECODE, EXEC_WAIT, HALT, FAULT} state_t;
  localparam logic [2:0] FUN_HOLD = 3'b000;
  localparam logic [2:0] FUN_INC = 3'b001;
  localparam logic [2:0] REGSEL_PC = 3'b011;
  localparam logic [2:0] REGSEL_NONE = 3'b111;
  localparam logic [1:0] OUTD_PC = 2'b00;
  localparam logic MEM_EN = 1'b0;
  localparam logic MEM_READ = 1'b0;
  function automatic logic [2:0] sc_sat(input logic [2:0] s);
    return s == 3'd7 ? s : s + 3'd1;
  endfunction
endpackage

// File: rtl/fetch_sequencer_exec_watchdog.sv
// exec_watchdog: clearable cycle counter flagging the last permitted EXEC_WAIT cycle
module exec_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [7:0] count;
  assign expired = en && count == 8'(TIMEOUT - 1);
  always_ff @(posedge clk) begin
    if (rst || clr) count <= '0;
    else if (en) count <= count + 8'd1;
  end
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: two-byte instruction fetch, decode and execute handoff controller
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter logic [5:0] HALT_OPCODE = 6'h3F,
  parameter int EXEC_TIMEOUT = 64
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic        Stop,
  input  logic        ExecDone,
  input  logic [15:0] IROut,
  output logic        Mem_CS,
  output logic        Mem_WR,
  output logic        IR_Write,
  output logic        IR_LH,
  output logic [1:0]  ARF_OutDSel,
  output logic [2:0]  ARF_FunSel,
  output logic [2:0]  ARF_RegSel,
  output logic        ExecStart,
  output logic [5:0]  Opcode,
  output logic [2:0]  SC,
  output logic        Busy,
  output logic        Halted,
  output logic        Fault,
  output logic [15:0] InstrCount
);
  state_t state, next;
  logic stop_pend, halt_op, fetch, done, expired;
  assign halt_op = IROut[15:10] == HALT_OPCODE;
  assign fetch = state == FETCH_L || state == FETCH_H;
  assign done = state == EXEC_WAIT && ExecDone;
  assign Mem_CS = fetch ? MEM_EN : ~MEM_EN;
  assign Mem_WR = MEM_READ;
  assign IR_Write = fetch;
  assign IR_LH = state == FETCH_H;
  assign ARF_OutDSel = OUTD_PC;
  assign ARF_FunSel = fetch ? FUN_INC : FUN_HOLD;
  assign ARF_RegSel = fetch ? REGSEL_PC : REGSEL_NONE;
  assign ExecStart = state == DECODE && !halt_op;
  assign Busy = fetch || state == DECODE || state == EXEC_WAIT;
  assign Halted = state == HALT;
  assign Fault = state == FAULT;
  exec_watchdog #(.TIMEOUT(EXEC_TIMEOUT)) u_wdog (
    .clk(Clock),
    .rst(Reset),
    .clr(state == DECODE),
    .en(state == EXEC_WAIT && !ExecDone),
    .expired(expired)
  );
  always_comb begin
    next = state;
    case (state)
      IDLE:      next = Start ? FETCH_L : IDLE;
      FETCH_L:   next = FETCH_H;
      FETCH_H:   next = DECODE;
      DECODE:    next = halt_op ? HALT : EXEC_WAIT;
      EXEC_WAIT: next = ExecDone ? (stop_pend ? IDLE : FETCH_L) : (expired ? FAULT : EXEC_WAIT);
      default:   next = state;
    endcase
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
      SC <= '0;
      Opcode <= '0;
      InstrCount <= '0;
      stop_pend <= 1'b0;
    end else begin
      state <= next;
      SC <= next == FETCH_H ? 3'd1 : next == DECODE ? 3'd2 :
            next == EXEC_WAIT ? (state == EXEC_WAIT ? sc_sat(SC) : 3'd3) : 3'd0;
      if (state == DECODE) Opcode <= IROut[15:10];
      if (done) InstrCount <= InstrCount + 16'd1;
      // a Stop landing on a halting DECODE is dropped; a new Stop outranks the clear at ExecDone
      stop_pend <= (Busy && Stop && !(state == DECODE && halt_op)) || (stop_pend && !done);
    end
  end
endmodule
